// File: rtl/complex_divider_35_17_if.sv
// Handshake/data bundle for complex_divider_35_17.
// Ports: i_start, i_pr/i_pi (P), i_br/i_bi (B) into the divider; o_busy, o_done,
//        o_ar/o_ai (A), o_ovf, o_dz back out. master = requester, slave = divider.
interface complex_divider_35_17_if #(
    parameter int AW = 18,
    parameter int BW = 17,
    parameter int PW = 35
);
    logic                 i_start;
    logic signed [PW-1:0] i_pr;
    logic signed [PW-1:0] i_pi;
    logic signed [BW-1:0] i_br;
    logic signed [BW-1:0] i_bi;
    logic                 o_busy;
    logic                 o_done;
    logic signed [AW-1:0] o_ar;
    logic signed [AW-1:0] o_ai;
    logic                 o_ovf;
    logic                 o_dz;

    modport master (
        output i_start, i_pr, i_pi, i_br, i_bi,
        input  o_busy, o_done, o_ar, o_ai, o_ovf, o_dz
    );

    modport slave (
        input  i_start, i_pr, i_pi, i_br, i_bi,
        output o_busy, o_done, o_ar, o_ai, o_ovf, o_dz
    );
endinterface

// File: rtl/complex_divider_35_17.sv
// Complex divider A = P*conj(B)/|B|^2 with one shared serial restoring divider.
// Latency: o_done 2*NW+2 edges after the accepting edge; one request every 2*NW+3 cycles.
// Backpressure: i_start ignored while o_busy=1; results held until the next o_done.
// Ports: i_clk, i_rst (async, active high), bus (slave modport of complex_divider_35_17_if).
module complex_divider_35_17 #(
    parameter int AW = 18,
    parameter int BW = 17,
    parameter int PW = 35,
    parameter int NW = 53,
    parameter int DW = 34
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    complex_divider_35_17_if.slave bus
);
    localparam int CW = $clog2(NW);
    localparam logic [NW-1:0] POS_MAX = (NW'(1) << (AW-1)) - NW'(1);
    localparam logic [NW-1:0] NEG_MAX = NW'(1) << (AW-1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIVR, S_DIVI, S_DONE} state_t;

    state_t               state;
    logic signed [PW-1:0] pr_q, pi_q;
    logic signed [BW-1:0] br_q, bi_q;
    logic [DW-1:0]        den_q;
    logic                 neg_r, neg_i;
    logic [NW-1:0]        ni_mag;     // imag numerator waits here while the real part divides
    logic [NW-1:0]        dvd;        // dividend, shifted out MSB first
    logic [DW-1:0]        rem;        // partial remainder, always < den
    logic [NW-1:0]        quo;        // quotient bits shifted in LSB side
    logic [NW-1:0]        qr_mag;     // finished real quotient magnitude
    logic [CW-1:0]        cnt;

    // Products are formed at full numerator width so nothing is truncated.
    logic signed [NW-1:0] pr_x, pi_x, br_x, bi_x, nr_c, ni_c;
    logic signed [DW-1:0] br_d, bi_d;
    logic [DW-1:0]        den_c;
    logic [NW-1:0]        nr_mag_c, ni_mag_c;

    assign pr_x  = {{(NW-PW){pr_q[PW-1]}}, pr_q};
    assign pi_x  = {{(NW-PW){pi_q[PW-1]}}, pi_q};
    assign br_x  = {{(NW-BW){br_q[BW-1]}}, br_q};
    assign bi_x  = {{(NW-BW){bi_q[BW-1]}}, bi_q};
    assign br_d  = {{(DW-BW){br_q[BW-1]}}, br_q};
    assign bi_d  = {{(DW-BW){bi_q[BW-1]}}, bi_q};
    assign nr_c  = pr_x * br_x + pi_x * bi_x;
    assign ni_c  = pi_x * br_x - pr_x * bi_x;
    // Sum of squares reaches 2^33, which only fits when read as unsigned.
    assign den_c = $unsigned(br_d * br_d + bi_d * bi_d);
    assign nr_mag_c = nr_c[NW-1] ? $unsigned(-nr_c) : $unsigned(nr_c);
    assign ni_mag_c = ni_c[NW-1] ? $unsigned(-ni_c) : $unsigned(ni_c);

    // One restoring step. rem_sh < 2*den, so a trial subtraction that
    // succeeds never sets the top bit and a failing one always does.
    logic [DW:0]   rem_sh, rem_sub;
    logic          q_bit;
    logic [DW-1:0] rem_nxt;
    logic [NW-1:0] quo_nxt;
    logic          dz;

    assign rem_sh  = {rem, dvd[NW-1]};
    assign rem_sub = rem_sh - {1'b0, den_q};
    assign q_bit   = ~rem_sub[DW];
    assign rem_nxt = q_bit ? rem_sub[DW-1:0] : rem_sh[DW-1:0];
    assign quo_nxt = {quo[NW-2:0], q_bit};
    assign dz      = (den_q == '0);

    // Returns {ovf, value}: applies sign and clamps to the AW-bit signed range.
    function automatic logic [AW:0] sat(input logic neg, input logic [NW-1:0] mag);
        logic [AW-1:0] t;
        t = mag[AW-1:0];
        if (!neg) begin
            if (mag > POS_MAX) sat = {1'b1, POS_MAX[AW-1:0]};
            else               sat = {1'b0, t};
        end else begin
            if (mag > NEG_MAX) sat = {1'b1, NEG_MAX[AW-1:0]};
            else               sat = {1'b0, -t};
        end
    endfunction

    logic [AW:0] sr_c, si_c;
    assign sr_c = sat(neg_r, qr_mag);
    assign si_c = sat(neg_i, quo);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= S_IDLE;
            pr_q       <= '0;
            pi_q       <= '0;
            br_q       <= '0;
            bi_q       <= '0;
            den_q      <= '0;
            neg_r      <= 1'b0;
            neg_i      <= 1'b0;
            ni_mag     <= '0;
            dvd        <= '0;
            rem        <= '0;
            quo        <= '0;
            qr_mag     <= '0;
            cnt        <= '0;
            bus.o_busy <= 1'b0;
            bus.o_done <= 1'b0;
            bus.o_ar   <= '0;
            bus.o_ai   <= '0;
            bus.o_ovf  <= 1'b0;
            bus.o_dz   <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        pr_q       <= bus.i_pr;
                        pi_q       <= bus.i_pi;
                        br_q       <= bus.i_br;
                        bi_q       <= bus.i_bi;
                        bus.o_busy <= 1'b1;
                        state      <= S_MUL;
                    end
                end
                S_MUL: begin
                    den_q  <= den_c;
                    neg_r  <= nr_c[NW-1];
                    neg_i  <= ni_c[NW-1];
                    dvd    <= nr_mag_c;
                    ni_mag <= ni_mag_c;
                    rem    <= '0;
                    quo    <= '0;
                    cnt    <= '0;
                    state  <= S_DIVR;
                end
                S_DIVR, S_DIVI: begin
                    // With den = 0 the divider idles but the step count is kept,
                    // so latency does not depend on the operands.
                    if (!dz) begin
                        dvd <= dvd << 1;
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                    end
                    if (cnt == CW'(NW-1)) begin
                        cnt <= '0;
                        if (state == S_DIVR) begin
                            qr_mag <= dz ? '0 : quo_nxt;
                            dvd    <= ni_mag;
                            rem    <= '0;
                            quo    <= '0;
                            state  <= S_DIVI;
                        end else begin
                            state  <= S_DONE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (dz) begin
                        bus.o_ar  <= '0;
                        bus.o_ai  <= '0;
                        bus.o_ovf <= 1'b0;
                        bus.o_dz  <= 1'b1;
                    end else begin
                        bus.o_ar  <= sr_c[AW-1:0];
                        bus.o_ai  <= si_c[AW-1:0];
                        bus.o_ovf <= sr_c[AW] | si_c[AW];
                        bus.o_dz  <= 1'b0;
                    end
                    bus.o_done <= 1'b1;
                    bus.o_busy <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_divider_35_17.sv
// Scoreboard bench for complex_divider_35_17: directed vectors, back-to-back,
// busy-ignore, mid-operation reset, and random A*B round trips.
module tb_complex_divider_35_17;
    localparam int LAT = 108;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    complex_divider_35_17_if bus ();

    complex_divider_35_17 dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic signed [17:0] ar;
        logic signed [17:0] ai;
        logic               ovf;
        logic               dz;
        int                 scyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every o_done must match the oldest outstanding request.
    always @(negedge i_clk) begin
        if (bus.o_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ar", bus.o_ar, e.ar);
                chk("ai", bus.o_ai, e.ai);
                chk("ovf", bus.o_ovf, e.ovf);
                chk("dz", bus.o_dz, e.dz);
                chk("latency", cyc - e.scyc, LAT);
                chk("busy_at_done", bus.o_busy, 0);
            end
        end
    end

    // Call at a negedge with the DUT idle. Returns #1 after the accepting edge.
    task automatic run(input longint pr, input longint pi, input longint br, input longint bi,
                       input longint ear, input longint eai, input logic eovf, input logic edz,
                       input bit push);
        exp_t x;
        bus.i_pr    = pr[34:0];
        bus.i_pi    = pi[34:0];
        bus.i_br    = br[16:0];
        bus.i_bi    = bi[16:0];
        bus.i_start = 1'b1;
        @(posedge i_clk);
        #1;
        if (push) begin
            x.ar   = ear[17:0];
            x.ai   = eai[17:0];
            x.ovf  = eovf;
            x.dz   = edz;
            x.scyc = cyc;
            sb.push_back(x);
        end
        bus.i_start = 1'b0;
        // Operands are latched; scramble them to prove it.
        bus.i_pr = 35'({$urandom(), $urandom()});
        bus.i_pi = 35'({$urandom(), $urandom()});
        bus.i_br = 17'($urandom());
        bus.i_bi = 17'($urandom());
        chk("busy_after_start", bus.o_busy, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge i_clk);
            if (bus.o_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_seen", 0, 1);
    endtask

    initial begin
        logic signed [17:0] a_r, a_i;
        logic signed [16:0] b_r, b_i;
        longint p_r, p_i;

        bus.i_start = 1'b0;
        bus.i_pr    = '0;
        bus.i_pi    = '0;
        bus.i_br    = '0;
        bus.i_bi    = '0;
        repeat (3) @(negedge i_clk);
        chk("rst_ar", bus.o_ar, 0);
        chk("rst_ai", bus.o_ai, 0);
        chk("rst_ovf", bus.o_ovf, 0);
        chk("rst_dz", bus.o_dz, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_busy", bus.o_busy, 0);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Basic recovery and exact latency.
        run(25, 25, 4, -3, 1, 7, 0, 0, 1);
        wait_idle();

        // Negative parts, then a start in the o_done cycle.
        run(-5, 10, -3, -4, -1, -2, 0, 0, 1);
        wait_done();
        run(7, 0, 2, 0, 3, 0, 0, 0, 1);
        wait_idle();

        // Truncation toward zero, positive saturation.
        run(-7, 0, 2, 0, -3, 0, 0, 0, 1);
        wait_idle();
        run(131072, 0, 1, 0, 131071, 0, 1, 0, 1);
        wait_idle();

        // Most negative value fits; B = 0 flagged with zero result.
        run(-131072, 0, 1, 0, -131072, 0, 0, 0, 1);
        wait_idle();
        run(5, 5, 0, 0, 0, 0, 0, 1, 1);
        wait_idle();

        // Start while busy must be ignored.
        run(100, -50, 3, 1, 25, -25, 0, 0, 1);
        repeat (20) @(negedge i_clk);
        bus.i_pr    = 35'sd1;
        bus.i_pi    = 35'sd1;
        bus.i_br    = 17'sd1;
        bus.i_bi    = 17'sd0;
        bus.i_start = 1'b1;
        @(negedge i_clk);
        bus.i_start = 1'b0;
        chk("busy_during_ignore", bus.o_busy, 1);
        wait_idle();
        repeat (120) @(negedge i_clk);

        // Reset mid-operation: outputs cleared, no o_done afterwards.
        run(1000, 0, 3, 0, 0, 0, 0, 0, 0);
        repeat (48) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("midrst_ar", bus.o_ar, 0);
        chk("midrst_ai", bus.o_ai, 0);
        chk("midrst_busy", bus.o_busy, 0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (120) @(negedge i_clk);
        chk("post_rst_busy", bus.o_busy, 0);
        run(25, 25, 4, -3, 1, 7, 0, 0, 1);
        wait_idle();

        // Random round trips: P = A*B, expect A back exactly.
        for (int n = 0; n < 400; n++) begin
            a_r = 18'($urandom());
            a_i = 18'($urandom());
            do begin
                b_r = 17'($urandom());
                b_i = 17'($urandom());
            end while ((b_r == 0 && b_i == 0) || b_r == -17'sd65536 || b_i == -17'sd65536);
            p_r = longint'(a_r) * longint'(b_r) - longint'(a_i) * longint'(b_i);
            p_i = longint'(a_r) * longint'(b_i) + longint'(a_i) * longint'(b_r);
            run(p_r, p_i, longint'(b_r), longint'(b_i), longint'(a_r), longint'(a_i), 0, 0, 1);
            wait_idle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
